// File: rtl/reg_wr_arb_if.sv
// Bundle for the register-file write arbiter: two requester ports plus the write-side bus.
// master = environment (drives requests, observes writes); slave = the arbiter.
interface reg_wr_arb_if #(
  parameter int DATA_W = 16
);
  logic              a_valid;
  logic [3:0]        a_dest;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [3:0]        b_dest;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              wr_stall;
  logic [3:0]        wr_op;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_src;
  logic              err_rsvd;
  logic              idle;

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data, wr_stall,
    input  a_ready, b_ready, wr_op, wr_data, wr_en, wr_src, err_rsvd, idle
  );

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, wr_stall,
    output a_ready, b_ready, wr_op, wr_data, wr_en, wr_src, err_rsvd, idle
  );
endinterface

// File: rtl/reg_wr_arb.sv
// Two-port write arbiter for the register file: a 2-deep FIFO per requester,
// round-robin grant on the FIFO heads, one registered write per cycle.
module reg_wr_arb #(
  parameter int DATA_W   = 16,
  parameter int RSVD_REG = 10
) (
  input  logic         clk,
  input  logic         resetn,
  reg_wr_arb_if.slave  bus
);
  localparam int         EW   = 4 + DATA_W;
  localparam logic [3:0] RSVD = 4'(RSVD_REG);

  // fifo_q[port][slot]; slot 0 is always the head
  logic [EW-1:0]     fifo_q [2][2];
  logic [EW-1:0]     fifo_d [2][2];
  logic [1:0]        cnt_q  [2];
  logic [1:0]        cnt_d  [2];
  logic              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic              err_rsvd_q, err_rsvd_d;
  logic              wr_src_q, wr_src_d;
  logic [3:0]        wr_op_q, wr_op_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              in_valid [2];
  logic [EW-1:0]     in_ent   [2];
  logic              rdy      [2];
  logic              head_vld [2];
  logic              push     [2];
  logic              pop      [2];
  logic [1:0]        wr_idx   [2];
  logic              grant_vld;
  logic              grant_port;
  logic [EW-1:0]     head_ent;
  logic [3:0]        head_dest;

  always_comb begin
    in_valid[0] = bus.a_valid;
    in_valid[1] = bus.b_valid;
    in_ent[0]   = {bus.a_dest, bus.a_data};
    in_ent[1]   = {bus.b_dest, bus.b_data};

    for (int p = 0; p < 2; p++) begin
      rdy[p]      = resetn && (cnt_q[p] != 2'd2);
      head_vld[p] = (cnt_q[p] != 2'd0);
    end

    grant_vld = !bus.wr_stall && (head_vld[0] || head_vld[1]);
    if (head_vld[0] && head_vld[1]) grant_port = ~last_grant_q;
    else                            grant_port = head_vld[1];

    head_ent  = fifo_q[grant_port][0];
    head_dest = head_ent[EW-1 -: 4];

    fifo_d = fifo_q;
    for (int p = 0; p < 2; p++) begin
      push[p]   = in_valid[p] && rdy[p];
      pop[p]    = grant_vld && (grant_port == p[0]);
      // a push lands behind whatever survives this edge's pop
      wr_idx[p] = cnt_q[p] - {1'b0, pop[p]};
      if (pop[p])  fifo_d[p][0] = fifo_q[p][1];
      if (push[p]) fifo_d[p][wr_idx[p][0]] = in_ent[p];
      cnt_d[p]  = cnt_q[p] + {1'b0, push[p]} - {1'b0, pop[p]};
    end
  end

  always_comb begin
    wr_en_d      = 1'b0;
    err_rsvd_d   = 1'b0;
    wr_op_d      = wr_op_q;
    wr_data_d    = wr_data_q;
    wr_src_d     = wr_src_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      last_grant_d = grant_port;
      if (head_dest == RSVD) begin
        err_rsvd_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_op_d   = head_dest;
        wr_data_d = head_ent[DATA_W-1:0];
        wr_src_d  = grant_port;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q[0]     <= 2'd0;
      cnt_q[1]     <= 2'd0;
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      err_rsvd_q   <= 1'b0;
      wr_op_q      <= 4'd0;
      wr_data_q    <= '0;
      wr_src_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      err_rsvd_q   <= err_rsvd_d;
      wr_op_q      <= wr_op_d;
      wr_data_q    <= wr_data_d;
      wr_src_q     <= wr_src_d;
    end
  end

  // entry storage needs no reset; the counts alone define validity
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.a_ready  = rdy[0];
  assign bus.b_ready  = rdy[1];
  assign bus.wr_en    = wr_en_q;
  assign bus.err_rsvd = err_rsvd_q;
  assign bus.wr_op    = wr_op_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_src   = wr_src_q;
  assign bus.idle     = (cnt_q[0] == 2'd0) && (cnt_q[1] == 2'd0) && !wr_en_q;
endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: a queue-based reference model predicts each
// write; a negedge monitor compares outputs and pops expected writes.
module tb_reg_wr_arb;
  localparam int         DW    = 16;
  localparam logic [3:0] RSVD4 = 4'd10;

  typedef struct {
    logic          err;
    logic [3:0]    op;
    logic [DW-1:0] data;
    logic          src;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  reg_wr_arb_if #(.DATA_W(DW)) bus();

  reg_wr_arb #(.DATA_W(DW), .RSVD_REG(10)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [3+DW:0] qa[$];
  logic [3+DW:0] qb[$];
  exp_t          exp_q[$];
  logic          last_b = 1'b1;
  logic          m_wr_en = 1'b0, m_err = 1'b0, m_src = 1'b0;
  logic [3:0]    m_op = 4'd0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(posedge clk) begin
    logic          acc_a, acc_b, ha, hb, gv, g;
    logic [3+DW:0] e;
    exp_t          x;
    if (!resetn) begin
      qa.delete();
      qb.delete();
      exp_q.delete();
      last_b  = 1'b1;
      m_wr_en = 1'b0;
      m_err   = 1'b0;
      m_op    = 4'd0;
      m_data  = '0;
      m_src   = 1'b0;
    end else begin
      acc_a = bus.a_valid && (qa.size() < 2);
      acc_b = bus.b_valid && (qb.size() < 2);
      ha    = (qa.size() != 0);
      hb    = (qb.size() != 0);
      gv    = !bus.wr_stall && (ha || hb);
      g     = (ha && hb) ? !last_b : hb;
      m_wr_en = 1'b0;
      m_err   = 1'b0;
      if (gv) begin
        e      = g ? qb.pop_front() : qa.pop_front();
        last_b = g;
        if (e[3+DW:DW] == RSVD4) begin
          m_err = 1'b1;
          x = '{1'b1, 4'd0, '0, 1'b0};
        end else begin
          m_wr_en = 1'b1;
          m_op    = e[3+DW:DW];
          m_data  = e[DW-1:0];
          m_src   = g;
          x = '{1'b0, e[3+DW:DW], e[DW-1:0], g};
        end
        exp_q.push_back(x);
      end
      if (acc_a) qa.push_back({bus.a_dest, bus.a_data});
      if (acc_b) qb.push_back({bus.b_dest, bus.b_data});
    end
  end

  always @(negedge clk) begin
    exp_t x;
    chk("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
    chk("err_rsvd", 32'(bus.err_rsvd), 32'(m_err));
    chk("wr_op", 32'(bus.wr_op), 32'(m_op));
    chk("wr_data", 32'(bus.wr_data), 32'(m_data));
    chk("wr_src", 32'(bus.wr_src), 32'(m_src));
    chk("a_ready", 32'(bus.a_ready), 32'(resetn && (qa.size() < 2)));
    chk("b_ready", 32'(bus.b_ready), 32'(resetn && (qb.size() < 2)));
    chk("idle", 32'(bus.idle), 32'((qa.size() == 0) && (qb.size() == 0) && !m_wr_en));
    if (bus.wr_en || bus.err_rsvd) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(1), 32'(0));
      end else begin
        x = exp_q.pop_front();
        chk("sb_err", 32'(bus.err_rsvd), 32'(x.err));
        if (!x.err) begin
          chk("sb_op", 32'(bus.wr_op), 32'(x.op));
          chk("sb_data", 32'(bus.wr_data), 32'(x.data));
          chk("sb_src", 32'(bus.wr_src), 32'(x.src));
        end
      end
    end
  end

  task automatic cyc(input logic av, input logic [3:0] ad, input logic [DW-1:0] adt,
                     input logic bv, input logic [3:0] bd, input logic [DW-1:0] bdt,
                     input logic st, input logic rn);
    bus.a_valid  = av;
    bus.a_dest   = ad;
    bus.a_data   = adt;
    bus.b_valid  = bv;
    bus.b_dest   = bd;
    bus.b_data   = bdt;
    bus.wr_stall = st;
    resetn       = rn;
    @(posedge clk);
    #2;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.a_valid  = 1'b0;
    bus.a_dest   = 4'd0;
    bus.a_data   = '0;
    bus.b_valid  = 1'b0;
    bus.b_dest   = 4'd0;
    bus.b_data   = '0;
    bus.wr_stall = 1'b0;
    resetn       = 1'b0;
    @(posedge clk);
    #2;
    cyc(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
    quiet(2);

    // single A write, then drain to idle
    cyc(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, '0, 1'b0, 1'b1);
    quiet(4);

    // both ports streaming: alternating grants
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 4'd1, 16'(16'hA000 + i), 1'b1, 4'd2, 16'(16'hB000 + i), 1'b0, 1'b1);
    quiet(6);

    // stall while pushing 3 on A; only 2 accepted
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'(4 + i), 16'(16'h5500 + i), 1'b0, 4'd0, '0, 1'b1, 1'b1);
    cyc(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b1, 1'b1);
    quiet(5);

    // reserved destination on B, then a simultaneous request goes to A
    cyc(1'b0, 4'd0, '0, 1'b1, 4'd10, 16'hDEAD, 1'b0, 1'b1);
    quiet(1);
    cyc(1'b1, 4'd7, 16'h0707, 1'b1, 4'd8, 16'h0808, 1'b0, 1'b1);
    quiet(5);

    // fill both FIFOs under stall, then reset mid-operation
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 4'd5, 16'(16'hC000 + i), 1'b1, 4'd6, 16'(16'hD000 + i), 1'b1, 1'b1);
    cyc(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
    quiet(5);

    // continuous A only: push and pop on the same edge at count 1
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 4'(i), 16'(16'h3300 + i), 1'b0, 4'd0, '0, 1'b0, 1'b1);
    quiet(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 6, 4'($urandom), 16'($urandom),
          $urandom_range(0, 9) < 6, 4'($urandom), 16'($urandom),
          $urandom_range(0, 9) < 2, $urandom_range(0, 99) != 0);
    quiet(10);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: REG_WR_ARB

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the write-data width.
REQ-002 SHALL have parameter RSVD_REG, default 10, the register index that has no write select and is never written.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have ports a_valid input 1, a_dest input 4, a_data input DATA_W, a_ready output 1, forming requester A (ALU result); the handshake is valid/ready.
REQ-006 SHALL have ports b_valid input 1, b_dest input 4, b_data input DATA_W, b_ready output 1, forming requester B (load result); the handshake is valid/ready.
REQ-007 SHALL have port wr_stall, input, 1, which blocks grants while the register file is busy.
REQ-008 SHALL have port wr_op, output, 4, the destination index; it drives the write-select decoder op[11:8].
REQ-009 SHALL have ports wr_data output DATA_W, wr_en output 1 (write strobe), and wr_src output 1 (0=A, 1=B).
REQ-010 SHALL have port err_rsvd, output, 1, a one-cycle pulse indicating a discarded write to RSVD_REG.
REQ-011 SHALL have port idle, output, 1, which is high when both FIFOs are empty and wr_en=0.

Function
REQ-012 SHALL hold a 2-entry FIFO per requester; each entry is {dest, data}; order within a port is preserved.
REQ-013 SHALL drive x_ready high iff resetn=1 and the FIFO count is less than 2; ready is computed from the registered count only, with no same-cycle pop-through.
REQ-014 SHALL push an entry at a rising edge where x_valid=1 and x_ready=1; x_valid with x_ready=0 has no effect.
REQ-015 SHALL, when a push and a pop occur in the same edge at count=1, leave the count at 1, with the new entry becoming the head.
REQ-016 SHALL arbitrate each cycle on the FIFO heads: if only one head is valid, that head wins; if both are valid, the port not granted last wins (round-robin).
REQ-017 SHALL, when wr_stall=1, make no grant and no pop, keep last_grant unchanged, and drive wr_en=0 in the following cycle.
REQ-018 SHALL, on a grant of a head whose dest is not RSVD_REG: pop it; at the next edge load wr_op=dest, wr_data=data, wr_src=port, wr_en=1; and update last_grant to that port.
REQ-019 SHALL, on a grant of a head whose dest equals RSVD_REG: pop it; at the next edge set wr_en=0 and err_rsvd=1 for one cycle; and update last_grant; this counts as that port's grant.
REQ-020 SHALL, in a cycle with no grant, deassert wr_en and err_rsvd at the next edge while holding wr_op, wr_data, and wr_src.
REQ-021 SHALL have a latency of two edges: an entry accepted at edge k drives wr_en high between edges k+1 and k+2, provided it is granted at k+1.
REQ-022 SHALL sustain a maximum throughput of one write per cycle; with both ports continuously valid and no stall, grants alternate A,B,A,B.
REQ-023 SHALL NOT merge or order same-dest writes across ports; only per-port order is guaranteed.

Reset
REQ-024 SHALL, at a rising edge with resetn=0, clear both FIFO counts, set wr_en=0, err_rsvd=0, wr_op=0, wr_data=0, wr_src=0, and set last_grant=B so that A wins first.
REQ-025 SHALL hold a_ready and b_ready at 0 while resetn=0, ignore pushes, and report idle=1 from the first edge after reset assertion.
REQ-026 SHALL, on a reset asserted mid-operation, discard all pending entries; no wr_en is issued for them after reset release.

Verification
REQ-027 SHALL be verified by this scenario: a single push on A (dest=3, data=16'h1234) at edge k -> wr_en=1, wr_op=3, wr_data=16'h1234, wr_src=0 between edges k+1 and k+2, and idle=1 afterwards.
REQ-028 SHALL be verified by this scenario: both ports are valid every cycle (A dest=1, B dest=2) with no stall -> wr_src sequence 0,1,0,1 and one write per cycle.
REQ-029 SHALL be verified by this scenario: with wr_stall=1, push 3 A entries -> only 2 are accepted and a_ready=0; after wr_stall drops, writes occur in push order and a_ready rises after the first pop.
REQ-030 SHALL be verified by this scenario: a push on B with dest=10 -> wr_en stays 0, err_rsvd=1 for exactly one cycle, and the next A/B request is granted to A.
REQ-031 SHALL be verified by this scenario: resetn=0 for one edge while both FIFOs hold 2 entries -> no wr_en after release, idle=1, and a_ready=b_ready=1 one edge after release.
REQ-032 SHALL be verified by this scenario: a push and a pop on the same edge at count=1 -> count remains 1 and the FIFO order is preserved.
